// File: rtl/alu_rf_master_pkg.sv
// Shared types for alu_rf_master: ALU op encoding and FSM states.
// Optional ADD/SUB saturation is enabled with ALU_RF_MASTER_SAT_EN.
package alu_rf_master_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_CAPB = 3'd3,
    S_EXEC = 3'd4,
    S_WB   = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/alu_rf_master_alu.sv
// Combinational ALU for alu_rf_master.
// ALU_RF_MASTER_SAT_EN: ADD/SUB clamp as signed instead of wrapping.
import alu_rf_master_pkg::*;

module alu_rf_master_alu #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] dif;
  logic [DATA_W-1:0] add_y;
  logic [DATA_W-1:0] sub_y;
  logic [4:0]        sh;

  assign sum = a + b;
  assign dif = a - b;
  assign sh  = b[4:0];

`ifdef ALU_RF_MASTER_SAT_EN
  localparam logic [DATA_W-1:0] SMAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic add_ovf;
  logic sub_ovf;
  logic [DATA_W-1:0] clamp;

  assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) &&
                   (sum[DATA_W-1] != a[DATA_W-1]);
  assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) &&
                   (dif[DATA_W-1] != a[DATA_W-1]);
  // Any signed overflow saturates toward the sign of A.
  assign clamp = a[DATA_W-1] ? SMIN : SMAX;
  assign add_y = add_ovf ? clamp : sum;
  assign sub_y = sub_ovf ? clamp : dif;
`else
  assign add_y = sum;
  assign sub_y = dif;
`endif

  always_comb begin
    y = '0;
    unique case (alu_op_t'(op))
      OP_ADD:  y = add_y;
      OP_SUB:  y = sub_y;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_PASS: y = a;
    endcase
  end

endmodule

// File: rtl/alu_rf_master.sv
// Sequences one ALU command through an external registered RF.
// ALU_RF_MASTER_SAT_EN selects saturating ADD/SUB in the ALU.
import alu_rf_master_pkg::*;

module alu_rf_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_srcA,
  input  logic [ADDR_W-1:0] cmd_srcB,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  state_t            state;
  alu_op_t           op_q;
  logic [ADDR_W-1:0] srca_q;
  logic [ADDR_W-1:0] srcb_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] alu_y;
  logic              rdy_q;

  // rdy_q rests at 1 in reset so ready rises the moment reset drops.
  assign cmd_ready = rdy_q & ~reset;

  alu_rf_master_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (alu_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      srca_q   <= '0;
      srcb_q   <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rdy_q    <= 1'b1;
      rf_we    <= 1'b0;
      rf_wAddr <= '0;
      rf_wData <= '0;
      rf_rAddr <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid && rdy_q) begin
            op_q     <= alu_op_t'(cmd_op);
            srca_q   <= cmd_srcA;
            srcb_q   <= cmd_srcB;
            dst_q    <= cmd_dst;
            rf_rAddr <= cmd_srcA;
            rdy_q    <= 1'b0;
            state    <= S_RDA;
          end
        end
        S_RDA: begin
          rf_rAddr <= srcb_q;
          state    <= S_RDB;
        end
        S_RDB: begin
          a_q   <= rf_rData;
          state <= S_CAPB;
        end
        S_CAPB: begin
          b_q   <= rf_rData;
          state <= S_EXEC;
        end
        S_EXEC: begin
          result   <= alu_y;
          rf_we    <= 1'b1;
          rf_wAddr <= dst_q;
          rf_wData <= alu_y;
          state    <= S_WB;
        end
        S_WB: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          rdy_q <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          rdy_q <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic unused;
  assign unused = ^srca_q;

endmodule

// File: doc/alu_rf_master.md
ALU_RF_MASTER -- requirements
Module: alu_rf_master

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL only be exercised at 32.
REQ-002 Parameter ADDR_W, default 4, register-file address width (16 entries).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_op  input  3  ALU operation.
REQ-008 cmd_srcA, cmd_srcB, cmd_dst  input  4 each  operand A, operand B and destination register addresses.
REQ-009 rf_we  output  1  register-file write enable; 0 means read cycle.
REQ-010 rf_wAddr  output  4  register-file write address.
REQ-011 rf_wData  output  32  register-file write data.
REQ-012 rf_rAddr  output  4  register-file read address.
REQ-013 rf_rData  input  32  register-file read data, registered: valid the cycle after rf_rAddr is presented with rf_we=0.
REQ-014 result  output  32  last computed result, held until the next EXEC.
REQ-015 done  output  1  one-cycle pulse after write-back completes.

Function
REQ-016 FSM states: IDLE, RDA, RDB, CAPB, EXEC, WB, DONE; all outputs registered.
REQ-017 IDLE: cmd_ready=1; cmd_valid&&cmd_ready at an edge latches op/srcA/srcB/dst and moves to RDA.
REQ-018 RDA: rf_we=0, rf_rAddr=srcA -> RDB.
REQ-019 RDB: rf_we=0, rf_rAddr=srcB; captures rf_rData as A at end of cycle -> CAPB.
REQ-020 CAPB: rf_we=0; captures rf_rData as B -> EXEC.
REQ-021 EXEC: result<=f(op,A,B) -> WB.
REQ-022 WB: rf_we=1, rf_wAddr=dst, rf_wData=result for exactly one cycle -> DONE.
REQ-023 DONE: done=1, cmd_ready=0 -> IDLE; command-to-done latency is 6 cycles after the accept edge.
REQ-024 rf_we SHALL be 0 in every state except WB.
REQ-025 Ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL by B[4:0], 6 SHR logical by B[4:0], 7 PASS A; ADD/SUB wrap modulo 2^32 by default.
REQ-026 cmd_valid outside IDLE SHALL be ignored (not queued); command inputs may change freely after accept.
REQ-027 srcA, srcB and dst may be equal; operands SHALL be the values before this command's write-back.

Reset
REQ-028 reset asserted SHALL force IDLE immediately; cmd_ready=0 while reset is high, 1 the first cycle after release.
REQ-029 Reset values: rf_we=0, rf_wAddr=0, rf_wData=0, rf_rAddr=0, result=0, done=0, latched A/B/op/addresses=0.
REQ-030 Reset mid-command SHALL abort with no write-back; an in-progress WB cycle is dropped.

Configuration
REQ-031 ALU_RF_MASTER_SAT_EN defined: ADD/SUB saturate as signed 32-bit (clamp to 0x7FFF_FFFF / 0x8000_0000); undefined: ADD/SUB wrap; other ops unaffected.

Structure
REQ-032 Shared package holds the op encoding enum (3-bit) and FSM state typedef.
REQ-033 One sub-module, alu_rf_master_alu: purely combinational op/A/B -> result, including the saturation option.

Verification
REQ-034 Preload r1=5, r2=7; cmd ADD src1,src2,dst3 -> WB writes 12 to r3; done pulses 6 cycles after accept.
REQ-035 r4=0x0000_0001, r5=4, SHL, dst=4 -> r4=0x10; following SUB src4,src4 -> 0.
REQ-036 r1=0x7FFF_FFFF, r2=1, ADD -> 0x8000_0000 without macro, 0x7FFF_FFFF with ALU_RF_MASTER_SAT_EN.
REQ-037 Assert reset in EXEC -> no rf_we pulse, outputs at reset values, cmd_ready=1 the cycle after release.
REQ-038 Hold cmd_valid high with a second command during a busy period -> only the first executes; the second is accepted in IDLE after done, back-to-back spacing 7 cycles.
REQ-039 All 8 ops with A=0xF0F0_F0F0, B=0x0000_0004 -> results match the golden model; rf_we high in exactly one cycle per command.
